// File: rtl/bitrev_unscramble.sv
`default_nettype none
// ============================================================================
// Module      : bitrev_unscramble
// Description : Ping-pong reorder buffer. Words arriving in bit-reversed frame
//               order are scattered into one of two banks and read back
//               sequentially in natural order. Full valid/ready flow control
//               on both sides, per-bank full tracking.
// Revision    : 1.0 - initial release
// ============================================================================
module bitrev_unscramble #(
    parameter int K  = 10,
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear_i,
    input  logic          valid_i,
    input  logic [DW-1:0] data_i,
    output logic          ready_o,
    output logic          valid_o,
    output logic [DW-1:0] data_o,
    input  logic          ready_i,
    output logic [1:0]    bank_full_o,
    output logic          frame_o
);

    localparam int          c_n       = 1 << K;
    localparam logic [K-1:0] c_cnt_max = '1;

    // Reverse the bit order of a frame index.
    function automatic logic [K-1:0] bitrev(input logic [K-1:0] x);
        logic [K-1:0] y;
        y = '0;
        for (int i = 0; i < K; i++) begin
            y[K-1-i] = x[i];
        end
        return y;
    endfunction

    logic [DW-1:0] r_mem [2][c_n];

    logic          r_wr_bank;
    logic          r_rd_bank;
    logic [K-1:0]  r_wr_cnt;
    logic [K-1:0]  r_rd_cnt;
    logic [1:0]    r_full;
    logic          r_valid;
    logic [DW-1:0] r_data;
    logic          r_frame;

    logic          w_ready;
    logic          w_wr_en;
    logic          w_wr_last;
    logic          w_load;
    logic          w_rd_last;
    logic [1:0]    w_full_next;

    // The writer only ever fills a bank that is not yet full, so ready never
    // depends on valid_i.
    assign w_ready   = !r_full[r_wr_bank];
    assign w_wr_en   = valid_i && w_ready && !clear_i;
    assign w_wr_last = (r_wr_cnt == c_cnt_max);
    assign w_load    = r_full[r_rd_bank] && (!r_valid || ready_i);
    assign w_rd_last = (r_rd_cnt == c_cnt_max);

    // Merge writer set and reader clear; they never address the same bank.
    always_comb begin
        w_full_next = r_full;
        if (w_wr_en && w_wr_last) begin
            w_full_next[r_wr_bank] = 1'b1;
        end
        if (w_load && w_rd_last) begin
            w_full_next[r_rd_bank] = 1'b0;
        end
    end

    // Scatter incoming words to their bit-reversed slot in the write bank.
    always_ff @(posedge clk_i) begin
        if (w_wr_en) begin
            r_mem[r_wr_bank][bitrev(r_wr_cnt)] <= data_i;
        end
    end

    // Control state and the registered output stage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_wr_cnt  <= '0;
            r_rd_cnt  <= '0;
            r_full    <= 2'b00;
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_frame   <= 1'b0;
        end else if (clear_i) begin
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_wr_cnt  <= '0;
            r_rd_cnt  <= '0;
            r_full    <= 2'b00;
            r_valid   <= 1'b0;
            r_data    <= '0;
            r_frame   <= 1'b0;
        end else begin
            r_full <= w_full_next;

            if (w_wr_en) begin
                r_wr_cnt <= r_wr_cnt + 1'b1;
                if (w_wr_last) begin
                    r_wr_bank <= ~r_wr_bank;
                end
            end

            if (w_load) begin
                r_data   <= r_mem[r_rd_bank][r_rd_cnt];
                r_valid  <= 1'b1;
                r_frame  <= w_rd_last;
                r_rd_cnt <= r_rd_cnt + 1'b1;
                if (w_rd_last) begin
                    r_rd_bank <= ~r_rd_bank;
                end
            end else if (r_valid && ready_i) begin
                // Word consumed and nothing ready to replace it.
                r_valid <= 1'b0;
                r_frame <= 1'b0;
            end
        end
    end

    assign ready_o     = w_ready;
    assign valid_o     = r_valid;
    assign data_o      = r_data;
    assign frame_o     = r_frame;
    assign bank_full_o = r_full;

endmodule
`default_nettype wire
